// File: rtl/raw_pkg.sv
// Shared types and constants for the RAW8/10/12 CSI-2 payload unpacker.
package raw_pkg;

  typedef enum logic [1:0] {
    RAW8  = 2'd0,
    RAW10 = 2'd1,
    RAW12 = 2'd2,
    RSVD  = 2'd3
  } raw_mode_e;

  localparam int PIX_W_DEF = 16;

  localparam int BPP_RAW8  = 8;
  localparam int BPP_RAW10 = 10;
  localparam int BPP_RAW12 = 12;

  // Bytes consumed per four-pixel group; 0 for the reserved encoding.
  function automatic logic [3:0] group_bytes(raw_mode_e m);
    case (m)
      RAW8:    return 4'd4;
      RAW10:   return 4'd5;
      RAW12:   return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/raw_group_unpack.sv
// Combinational unpack of one byte group (oldest byte in window[7:0]) into
// four LSB-justified, zero-extended pixels.
module raw_group_unpack
  import raw_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [47:0]        window,
  input  logic [1:0]         mode,
  output logic [4*PIX_W-1:0] pixels
);

  logic [7:0]           b   [6];
  logic [BPP_RAW8-1:0]  p8  [4];
  logic [BPP_RAW10-1:0] p10 [4];
  logic [BPP_RAW12-1:0] p12 [4];

  // Split the window into bytes and build every packing's pixels, then pick one.
  always_comb begin
    pixels = '0;
    for (int k = 0; k < 6; k++) begin
      b[k] = window[8*k +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      p8[k]  = b[k];
      p10[k] = {b[k], b[4][2*k +: 2]};
    end
    p12[0] = {b[0], b[2][3:0]};
    p12[1] = {b[1], b[2][7:4]};
    p12[2] = {b[3], b[5][3:0]};
    p12[3] = {b[4], b[5][7:4]};
    case (raw_mode_e'(mode))
      RAW8: begin
        for (int k = 0; k < 4; k++) pixels[k*PIX_W +: PIX_W] = PIX_W'(p8[k]);
      end
      RAW10: begin
        for (int k = 0; k < 4; k++) pixels[k*PIX_W +: PIX_W] = PIX_W'(p10[k]);
      end
      RAW12: begin
        for (int k = 0; k < 4; k++) pixels[k*PIX_W +: PIX_W] = PIX_W'(p12[k]);
      end
      default: pixels = '0;
    endcase
  end

endmodule

// File: rtl/raw_pixel_unpacker.sv
// CSI-2 RAW8/RAW10/RAW12 payload unpacker: byte stream in, four-pixel beats
// out, with per-line beat count and residual/reserved-mode error pulses.
module raw_pixel_unpacker
  import raw_pkg::*;
#(
  parameter int IN_BYTES = 2,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int CNT_W    = 16
) (
  input  logic                  rxbyteclkhs,
  input  logic                  reset,
  input  logic                  frame_active,
  input  logic                  line_valid,
  input  logic [1:0]            mode,
  input  logic [8*IN_BYTES-1:0] data_in,
  output logic [4*PIX_W-1:0]    data_out,
  output logic                  out_valid,
  output logic [CNT_W-1:0]      line_beats,
  output logic                  residual_err,
  output logic                  mode_err
);

  localparam logic [4:0] IN_B5 = 5'(IN_BYTES);

  // Bytes above the occupancy are always kept zero so appends can be ORed in.
  logic [95:0]      acc;
  logic [3:0]       occ;
  raw_mode_e        mode_q;
  logic             v_prev;
  logic [CNT_W-1:0] beat_cnt;

  logic             v;
  logic             line_start;
  logic             line_end;
  raw_mode_e        cur_mode;
  logic [3:0]       g;
  logic [95:0]      merged;
  logic [95:0]      acc_next;
  logic [4:0]       occ_sum;
  logic [3:0]       occ_next;
  logic             emit;
  logic [4*PIX_W-1:0] pix;

  // Line tracking, append of this cycle's bytes and group consumption.
  always_comb begin
    v          = frame_active & line_valid;
    line_start = v & ~v_prev;
    line_end   = ~v & v_prev;
    cur_mode   = line_start ? raw_mode_e'(mode) : mode_q;
    g          = group_bytes(cur_mode);
    merged     = acc | (96'(data_in) << {occ, 3'b000});
    occ_sum    = {1'b0, occ} + IN_B5;
    emit       = v & (cur_mode != RSVD) & (occ_sum >= {1'b0, g});
    acc_next   = merged;
    occ_next   = occ_sum[3:0];
    if (emit) begin
      acc_next = merged >> {g, 3'b000};
      occ_next = 4'(occ_sum - {1'b0, g});
    end
  end

  raw_group_unpack #(.PIX_W(PIX_W)) u_unpack (
    .window (merged[47:0]),
    .mode   (cur_mode),
    .pixels (pix)
  );

  // The line-end cycle itself reports leftover bytes, before occupancy clears.
  assign residual_err = line_end & (occ != 4'd0);

  // Accumulator, latched mode and per-line beat accounting.
  always_ff @(posedge rxbyteclkhs or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      occ        <= '0;
      mode_q     <= RAW8;
      v_prev     <= 1'b0;
      beat_cnt   <= '0;
      line_beats <= '0;
    end else begin
      v_prev <= v;
      if (v) begin
        if (line_start) mode_q <= cur_mode;
        if (cur_mode != RSVD) begin
          acc <= acc_next;
          occ <= occ_next;
        end
        if (emit) beat_cnt <= beat_cnt + CNT_W'(1);
      end else if (line_end) begin
        acc        <= '0;
        occ        <= '0;
        line_beats <= beat_cnt;
        beat_cnt   <= '0;
      end
    end
  end

  // Registered beat output and reserved-mode pulse.
  always_ff @(posedge rxbyteclkhs or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      out_valid <= emit;
      data_out  <= emit ? pix : '0;
      mode_err  <= line_start & (mode == 2'd3);
    end
  end

endmodule

// File: tb/tb_raw_pixel_unpacker.sv
module tb_raw_pixel_unpacker;

  logic clk = 1'b0;
  logic reset;

  logic        fa_a, lv_a;
  logic [1:0]  mode_a;
  logic [15:0] din_a;
  logic [63:0] dout_a;
  logic        ov_a, re_a, me_a;
  logic [15:0] lb_a;

  logic        fa_b, lv_b;
  logic [1:0]  mode_b;
  logic [31:0] din_b;
  logic [63:0] dout_b;
  logic        ov_b, re_b, me_b;
  logic [15:0] lb_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  raw_pixel_unpacker #(.IN_BYTES(2), .PIX_W(16), .CNT_W(16)) dut_a (
    .rxbyteclkhs(clk), .reset(reset), .frame_active(fa_a), .line_valid(lv_a),
    .mode(mode_a), .data_in(din_a), .data_out(dout_a), .out_valid(ov_a),
    .line_beats(lb_a), .residual_err(re_a), .mode_err(me_a));

  raw_pixel_unpacker #(.IN_BYTES(4), .PIX_W(16), .CNT_W(16)) dut_b (
    .rxbyteclkhs(clk), .reset(reset), .frame_active(fa_b), .line_valid(lv_b),
    .mode(mode_b), .data_in(din_b), .data_out(dout_b), .out_valid(ov_b),
    .line_beats(lb_b), .residual_err(re_b), .mode_err(me_b));

  // Behavioural model state, index 0 = dut_a, 1 = dut_b.
  logic [7:0]  mbuf [2][32];
  int          mcnt [2];
  bit          minl [2];
  int          mmode [2];
  int          mbcnt [2];
  bit          exp_ov [2];
  logic [63:0] exp_do [2];
  int          exp_lb [2];
  bit          exp_me [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic bit cur_v(input int i);
    return (i == 0) ? (fa_a & lv_a) : (fa_b & lv_b);
  endfunction

  function automatic int cur_mode(input int i);
    return (i == 0) ? int'(mode_a) : int'(mode_b);
  endfunction

  function automatic logic [7:0] cur_byte(input int i, input int k);
    return (i == 0) ? din_a[8*k +: 8] : din_b[8*k +: 8];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; minl[i] = 0; mmode[i] = 0; mbcnt[i] = 0;
      exp_ov[i] = 0; exp_do[i] = '0; exp_lb[i] = 0; exp_me[i] = 0;
    end
  endtask

  // One clock edge of the spec-level model: a byte queue popped G bytes at a time.
  task automatic model_edge();
    int nb, g, p [4];
    bit v;
    if (reset) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      nb = (i == 0) ? 2 : 4;
      v  = cur_v(i);
      exp_ov[i] = 0; exp_do[i] = '0; exp_me[i] = 0;
      if (v && !minl[i]) begin
        mmode[i]  = cur_mode(i);
        exp_me[i] = (mmode[i] == 3);
      end
      if (v && mmode[i] != 3) begin
        for (int k = 0; k < nb; k++) begin
          mbuf[i][mcnt[i]] = cur_byte(i, k);
          mcnt[i]++;
        end
        g = (mmode[i] == 0) ? 4 : (mmode[i] == 1) ? 5 : 6;
        if (mcnt[i] >= g) begin
          for (int k = 0; k < 4; k++) begin
            if (mmode[i] == 0)      p[k] = int'(mbuf[i][k]);
            else if (mmode[i] == 1) p[k] = int'(mbuf[i][k]) * 4 + ((int'(mbuf[i][4]) >> (2*k)) % 4);
          end
          if (mmode[i] == 2) begin
            p[0] = int'(mbuf[i][0]) * 16 + (int'(mbuf[i][2]) % 16);
            p[1] = int'(mbuf[i][1]) * 16 + (int'(mbuf[i][2]) / 16);
            p[2] = int'(mbuf[i][3]) * 16 + (int'(mbuf[i][5]) % 16);
            p[3] = int'(mbuf[i][4]) * 16 + (int'(mbuf[i][5]) / 16);
          end
          exp_do[i] = {p[3][15:0], p[2][15:0], p[1][15:0], p[0][15:0]};
          exp_ov[i] = 1;
          for (int k = 0; k + g < mcnt[i]; k++) mbuf[i][k] = mbuf[i][k + g];
          mcnt[i] -= g;
          mbcnt[i]++;
        end
      end
      if (!v && minl[i]) begin
        exp_lb[i] = mbcnt[i];
        mbcnt[i]  = 0;
        mcnt[i]   = 0;
      end
      minl[i] = v;
    end
  endtask

  task automatic compare_all();
    if (reset) model_clear();
    check("a.data_out",   dout_a, exp_do[0]);
    check("a.out_valid",  64'(ov_a), 64'(exp_ov[0]));
    check("a.line_beats", 64'(lb_a), 64'(exp_lb[0]));
    check("a.mode_err",   64'(me_a), 64'(exp_me[0]));
    check("a.residual",   64'(re_a), 64'(minl[0] && !cur_v(0) && mcnt[0] != 0));
    check("b.data_out",   dout_b, exp_do[1]);
    check("b.out_valid",  64'(ov_b), 64'(exp_ov[1]));
    check("b.line_beats", 64'(lb_b), 64'(exp_lb[1]));
    check("b.mode_err",   64'(me_b), 64'(exp_me[1]));
    check("b.residual",   64'(re_b), 64'(minl[1] && !cur_v(1) && mcnt[1] != 0));
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic set_a(input logic v, input logic [1:0] m, input logic [15:0] d);
    fa_a = v; lv_a = v; mode_a = m; din_a = d;
  endtask

  task automatic set_b(input logic v, input logic [1:0] m, input logic [31:0] d);
    fa_b = v; lv_b = v; mode_b = m; din_b = d;
  endtask

  localparam logic [63:0] BEAT_S1 = 64'h0113_00CE_0089_0044;
  localparam logic [63:0] BEAT_S2 = 64'h0346_0125_0CD2_0AB1;

  initial begin
    reset = 1'b1;
    set_a(0, 2'd0, 16'h0);
    set_b(0, 2'd0, 32'h0);
    model_clear();
    @(negedge clk);
    settle();
    check("reset.lb_a", 64'(lb_a), 64'd0);
    check("reset.dout_a", dout_a, 64'd0);
    advance();
    reset = 1'b0;
    cycle();

    // 1: RAW10 with one leftover byte
    set_a(1, 2'd1, 16'h2211); cycle();
    set_a(1, 2'd1, 16'h4433); cycle();
    set_a(1, 2'd1, 16'h00E4); settle();
    check("s1.no_early_valid", 64'(ov_a), 64'd0);
    advance();
    set_a(0, 2'd1, 16'h0); settle();
    check("s1.beat", dout_a, BEAT_S1);
    check("s1.valid", 64'(ov_a), 64'd1);
    check("s1.residual", 64'(re_a), 64'd1);
    advance();
    settle();
    check("s1.line_beats", 64'(lb_a), 64'd1);
    advance();

    // 2: RAW12 exact group
    set_a(1, 2'd2, 16'hCDAB); cycle();
    set_a(1, 2'd2, 16'h1221); cycle();
    set_a(1, 2'd2, 16'h6534); cycle();
    set_a(0, 2'd2, 16'h0); settle();
    check("s2.beat", dout_a, BEAT_S2);
    check("s2.residual", 64'(re_a), 64'd0);
    advance();
    cycle();

    // 3: RAW8 on the 4-byte instance, one beat per cycle
    set_b(1, 2'd0, 32'h0403_0201); cycle();
    set_b(1, 2'd0, 32'h0807_0605); settle();
    check("s3.beat0", dout_b, 64'h0004_0003_0002_0001);
    check("s3.valid0", 64'(ov_b), 64'd1);
    advance();
    set_b(1, 2'd0, 32'h0C0B_0A09); cycle();
    set_b(0, 2'd0, 32'h0); settle();
    check("s3.beat2", dout_b, 64'h000C_000B_000A_0009);
    advance();
    settle();
    check("s3.line_beats", 64'(lb_b), 64'd3);
    advance();

    // 4: RAW10 20-byte line with mid-line mode change, then an immediate RAW12 line
    for (int c = 0; c < 10; c++) begin
      set_a(1, (c >= 2) ? 2'd2 : 2'd1, {8'(8'h30 + 2*c + 1), 8'(8'h30 + 2*c)});
      cycle();
    end
    set_a(0, 2'd2, 16'h0); settle();
    check("s4.residual", 64'(re_a), 64'd0);
    advance();
    set_a(1, 2'd2, 16'hCDAB); settle();
    check("s4.line_beats", 64'(lb_a), 64'd4);
    advance();
    set_a(1, 2'd1, 16'h1221); cycle();
    set_a(1, 2'd1, 16'h6534); cycle();
    set_a(0, 2'd1, 16'h0); settle();
    check("s4.raw12_beat", dout_a, BEAT_S2);
    advance();
    cycle();

    // 5: reserved mode
    set_a(1, 2'd3, 16'hA5A5); cycle();
    set_a(1, 2'd3, 16'h5A5A); settle();
    check("s5.mode_err", 64'(me_a), 64'd1);
    advance();
    for (int c = 0; c < 3; c++) begin
      set_a(1, 2'd3, 16'(16'h1000 + c)); cycle();
    end
    set_a(0, 2'd3, 16'h0); settle();
    check("s5.residual", 64'(re_a), 64'd0);
    advance();
    settle();
    check("s5.line_beats", 64'(lb_a), 64'd0);
    advance();

    // 6: reset mid-line, then a clean RAW10 line
    set_a(1, 2'd1, 16'h2211); cycle();
    set_a(1, 2'd1, 16'h9933); cycle();
    reset = 1'b1;
    set_a(1, 2'd1, 16'h7777); settle();
    check("s6.rst_dout", dout_a, 64'd0);
    check("s6.rst_valid", 64'(ov_a), 64'd0);
    check("s6.rst_lb", 64'(lb_a), 64'd0);
    check("s6.rst_res", 64'(re_a), 64'd0);
    advance();
    reset = 1'b0;
    set_a(1, 2'd1, 16'h2211); cycle();
    set_a(1, 2'd1, 16'h4433); cycle();
    set_a(1, 2'd1, 16'h00E4); cycle();
    set_a(0, 2'd1, 16'h0); settle();
    check("s6.beat", dout_a, BEAT_S1);
    check("s6.valid", 64'(ov_a), 64'd1);
    advance();
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
